ring_router_gateway_arbiter: RTL and testbench

RING_ROUTER_GATEWAY_ARBITER -- requirements
Module: ring_router_gateway_arbiter

---
 rtl/ring_router_gateway_arbiter.sv | 150 +++++++++++++++
 tb/tb_ring_router_gateway_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_gateway_arbiter.sv
// rtl/ring_router_gateway_arbiter.sv - three-input packet arbiter feeding a registered ring output stage
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - asynchronous active-low reset
//   in_ring        - flit from the upstream ring        / in_ring_ready  - accept for in_ring
//   in_local       - flit from the local endpoint       / in_local_ready - accept for in_local
//   in_ext         - flit from the external gateway     / in_ext_ready   - accept for in_ext
//   out_ring       - registered flit toward the downstream ring
//   out_ring_ready - downstream accept
// Parameter FIXED_PRIO: 0 = round-robin, 1 = fixed priority ring > local > ext.

package dii_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;
endpackage

module ring_router_gateway_arbiter
    import dii_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_ring,
    output logic    in_ring_ready,
    input  dii_flit in_local,
    output logic    in_local_ready,
    input  dii_flit in_ext,
    output logic    in_ext_ready,
    output dii_flit out_ring,
    input  logic    out_ring_ready
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_RING,
        LOCK_LOCAL,
        LOCK_EXT
    } state_t;

    localparam logic [1:0] P_RING  = 2'd0;
    localparam logic [1:0] P_LOCAL = 2'd1;
    localparam logic [1:0] P_EXT   = 2'd2;

    state_t     state;
    logic [1:0] last_winner;
    logic [2:0] valids;
    logic [1:0] grant;
    logic       grant_valid;
    logic       can_load;
    logic       xfer;
    logic [1:0] cand1;
    logic [1:0] cand2;
    dii_flit    sel;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == P_EXT) ? P_RING : p + 2'd1;
    endfunction

    function automatic state_t lock_of(input logic [1:0] p);
        case (p)
            P_RING:  return LOCK_RING;
            P_LOCAL: return LOCK_LOCAL;
            default: return LOCK_EXT;
        endcase
    endfunction

    assign valids   = {in_ext.valid, in_local.valid, in_ring.valid};
    assign can_load = !out_ring.valid || out_ring_ready;
    assign cand1    = next_port(last_winner);
    assign cand2    = next_port(cand1);

    always_comb begin
        grant       = P_RING;
        grant_valid = 1'b0;
        case (state)
            LOCK_RING: begin
                grant       = P_RING;
                grant_valid = 1'b1;
            end
            LOCK_LOCAL: begin
                grant       = P_LOCAL;
                grant_valid = 1'b1;
            end
            LOCK_EXT: begin
                grant       = P_EXT;
                grant_valid = 1'b1;
            end
            default: begin
                grant_valid = |valids;
                if (FIXED_PRIO) begin
                    // Later assignments win, so scanning high to low leaves the lowest valid index.
                    for (int i = 2; i >= 0; i--) begin
                        if (valids[i]) grant = 2'(i);
                    end
                end else begin
                    // Search order cand1, cand2, last_winner; written farthest-first so the nearest wins.
                    if (valids[last_winner]) grant = last_winner;
                    if (valids[cand2])       grant = cand2;
                    if (valids[cand1])       grant = cand1;
                end
            end
        endcase
    end

    always_comb begin
        case (grant)
            P_RING:  sel = in_ring;
            P_LOCAL: sel = in_local;
            default: sel = in_ext;
        endcase
    end

    // Readys are forced low while reset is held, even though can_load is 1 then.
    assign in_ring_ready  = rst && grant_valid && can_load && (grant == P_RING);
    assign in_local_ready = rst && grant_valid && can_load && (grant == P_LOCAL);
    assign in_ext_ready   = rst && grant_valid && can_load && (grant == P_EXT);

    // A locked grant does not imply a valid flit: a stalled owner blocks everyone.
    assign xfer = grant_valid && can_load && sel.valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_winner <= P_EXT;
            out_ring    <= '0;
        end else begin
            if (can_load) begin
                out_ring.valid <= xfer;
                if (xfer) begin
                    out_ring.data <= sel.data;
                    out_ring.last <= sel.last;
                end
            end
            if (xfer) begin
                if (state == IDLE) begin
                    if (!FIXED_PRIO) last_winner <= grant;
                    if (!sel.last) state <= lock_of(grant);
                end else if (sel.last) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_router_gateway_arbiter.sv
// tb/tb_ring_router_gateway_arbiter.sv - self-checking bench for ring_router_gateway_arbiter

module tb_ring_router_gateway_arbiter;
    import dii_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    dii_flit in_ring, in_local, in_ext;
    logic    out_ring_ready;
    logic    r_ring_rdy, r_local_rdy, r_ext_rdy;
    logic    f_ring_rdy, f_local_rdy, f_ext_rdy;
    dii_flit r_out, f_out;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    logic [2:0] took = '0;

    // Reference model: lock owner (-1 = none), round-robin pointer, output register.
    int          m_lock = -1;
    int          m_ptr  = 2;
    logic        m_ov   = 1'b0;
    logic [15:0] m_od   = '0;
    logic        m_ol   = 1'b0;

    always #5 clk = ~clk;

    ring_router_gateway_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .in_ring(in_ring), .in_ring_ready(r_ring_rdy),
        .in_local(in_local), .in_local_ready(r_local_rdy),
        .in_ext(in_ext), .in_ext_ready(r_ext_rdy),
        .out_ring(r_out), .out_ring_ready(out_ring_ready)
    );

    ring_router_gateway_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .in_ring(in_ring), .in_ring_ready(f_ring_rdy),
        .in_local(in_local), .in_local_ready(f_local_rdy),
        .in_ext(in_ext), .in_ext_ready(f_ext_rdy),
        .out_ring(f_out), .out_ring_ready(out_ring_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic dii_flit mk(input logic [15:0] d, input logic l, input logic v);
        dii_flit f;
        f.data  = d;
        f.last  = l;
        f.valid = v;
        return f;
    endfunction

    function automatic logic [2:0] rdys();
        if (mode == 0) return {r_ext_rdy, r_local_rdy, r_ring_rdy};
        return {f_ext_rdy, f_local_rdy, f_ring_rdy};
    endfunction

    function automatic dii_flit outp();
        return (mode == 0) ? r_out : f_out;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        if (took[0]) in_ring.valid  = 1'b0;
        if (took[1]) in_local.valid = 1'b0;
        if (took[2]) in_ext.valid   = 1'b0;
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    dii_flit    c_fin [3];
    dii_flit    c_o;
    logic       c_can, c_xf;
    int         c_g;
    logic [2:0] c_er, c_r;

    always @(negedge clk) begin
        c_fin[0] = in_ring;
        c_fin[1] = in_local;
        c_fin[2] = in_ext;
        c_o      = outp();
        c_r      = rdys();
        if (!rst) begin
            chk("reset_out_valid", 32'(c_o.valid), 32'd0);
            chk("reset_out_flit", 32'({c_o.data, c_o.last}), 32'd0);
            chk("reset_readys", 32'(c_r), 32'd0);
            m_lock = -1;
            m_ptr  = 2;
            m_ov   = 1'b0;
            m_od   = '0;
            m_ol   = 1'b0;
            took   = '0;
        end else begin
            c_can = !m_ov || out_ring_ready;
            c_g   = -1;
            if (m_lock >= 0) begin
                c_g = m_lock;
            end else if (mode == 1) begin
                for (int i = 0; i < 3; i++)
                    if (c_g < 0 && c_fin[i].valid) c_g = i;
            end else begin
                for (int k = 1; k <= 3; k++)
                    if (c_g < 0 && c_fin[(m_ptr + k) % 3].valid) c_g = (m_ptr + k) % 3;
            end
            c_er = '0;
            if (c_g >= 0 && c_can) c_er[c_g] = 1'b1;
            chk("model_readys", 32'(c_r), 32'(c_er));
            chk("model_out_valid", 32'(c_o.valid), 32'(m_ov));
            if (m_ov) chk("model_out_flit", 32'({c_o.data, c_o.last}), 32'({m_od, m_ol}));
            took = c_r & {c_fin[2].valid, c_fin[1].valid, c_fin[0].valid};
            c_xf = (c_g >= 0) && c_can && c_fin[c_g].valid;
            if (c_can) m_ov = c_xf;
            if (c_xf) begin
                m_od = c_fin[c_g].data;
                m_ol = c_fin[c_g].last;
                if (m_lock < 0) begin
                    if (mode == 0) m_ptr = c_g;
                    if (!c_fin[c_g].last) m_lock = c_g;
                end else if (c_fin[c_g].last) begin
                    m_lock = -1;
                end
            end
        end
    end

    task automatic run_random(input int m, input int n);
        int      len [3];
        int      pos [3];
        int      seq [3];
        dii_flit f   [3];
        rst = 1'b0;
        mode = m;
        in_ring = '0;
        in_local = '0;
        in_ext = '0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            len[i] = $urandom_range(1, 4);
            pos[i] = 0;
            seq[i] = 0;
        end
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (took[i]) begin
                    seq[i]++;
                    pos[i]++;
                    if (pos[i] == len[i]) begin
                        pos[i] = 0;
                        len[i] = $urandom_range(1, 4);
                    end
                end
                f[i] = mk({i[1:0], seq[i][13:0]}, pos[i] == len[i] - 1, $urandom_range(0, 99) < 60);
            end
            in_ring  = f[0];
            in_local = f[1];
            in_ext   = f[2];
            out_ring_ready = $urandom_range(0, 99) < 70;
            rst = ($urandom_range(0, 599) != 0);
            step();
        end
        rst = 1'b1;
    endtask

    initial begin
        in_ring = '0;
        in_local = '0;
        in_ext = '0;
        out_ring_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset priority: ring, local, ext one per cycle.
        in_ring  = mk(16'h0001, 1'b1, 1'b1);
        in_local = mk(16'h0002, 1'b1, 1'b1);
        in_ext   = mk(16'h0003, 1'b1, 1'b1);
        #1 chk("prio_first_ready", 32'({r_ext_rdy, r_local_rdy, r_ring_rdy}), 32'b001);
        for (int k = 0; k < 3; k++) begin
            step();
            retire();
            chk("prio_order", 32'({r_out.valid, r_out.data}), 32'({1'b1, 16'(k + 1)}));
        end

        // Lock: local 3-flit packet excludes a waiting ring flit.
        in_ring = mk(16'h00B0, 1'b1, 1'b1);
        step();
        retire();
        chk("lock_pre", 32'({r_out.valid, r_out.data}), 32'h1_00B0);
        in_ring = mk(16'h00B1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            in_local = mk(16'h00A0 + 16'(k), k == 2, 1'b1);
            #1 chk("lock_readys", 32'({r_ring_rdy, r_local_rdy}), 32'b01);
            step();
            chk("lock_seq", 32'({r_out.valid, r_out.data}), 32'({1'b1, 16'h00A0 + 16'(k)}));
        end
        in_local.valid = 1'b0;
        step();
        retire();
        chk("lock_then_ring", 32'({r_out.valid, r_out.data}), 32'h1_00B1);

        // Backpressure hold and bubble-free release.
        in_ext = mk(16'h0055, 1'b1, 1'b1);
        step();
        retire();
        chk("bp_load", 32'({r_out.valid, r_out.data}), 32'h1_0055);
        out_ring_ready = 1'b0;
        in_ring = mk(16'h0066, 1'b1, 1'b1);
        repeat (4) begin
            #1 chk("bp_readys", 32'({r_ext_rdy, r_local_rdy, r_ring_rdy}), 32'd0);
            step();
            chk("bp_hold", 32'({r_out.valid, r_out.data, r_out.last}), 32'({1'b1, 16'h0055, 1'b1}));
        end
        out_ring_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(r_ring_rdy), 32'd1);
        step();
        retire();
        chk("bp_next", 32'({r_out.valid, r_out.data}), 32'h1_0066);

        // Mid-packet stall of the ext owner.
        in_ext = mk(16'h0070, 1'b0, 1'b1);
        step();
        in_ext.valid = 1'b0;
        chk("stall_head", 32'({r_out.valid, r_out.data}), 32'h1_0070);
        in_ring = mk(16'h0080, 1'b1, 1'b1);
        repeat (2) begin
            #1 chk("stall_ring_blocked", 32'(r_ring_rdy), 32'd0);
            step();
            chk("stall_gap", 32'(r_out.valid), 32'd0);
        end
        in_ext = mk(16'h0071, 1'b1, 1'b1);
        step();
        in_ext.valid = 1'b0;
        chk("stall_tail", 32'({r_out.valid, r_out.data, r_out.last}), 32'({1'b1, 16'h0071, 1'b1}));
        step();
        retire();
        chk("stall_ring_after", 32'({r_out.valid, r_out.data}), 32'h1_0080);

        // Reset while locked on local with a buffered flit.
        in_local = mk(16'h0090, 1'b0, 1'b1);
        step();
        in_local.valid = 1'b0;
        chk("rlock_buffered", 32'({r_out.valid, r_out.data}), 32'h1_0090);
        rst = 1'b0;
        #1 chk("rlock_async_clear", 32'(r_out.valid), 32'd0);
        chk("rlock_readys", 32'({r_ext_rdy, r_local_rdy, r_ring_rdy}), 32'd0);
        in_ring  = mk(16'h00C0, 1'b1, 1'b1);
        in_local = mk(16'h00D0, 1'b0, 1'b1);
        step();
        step();
        rst = 1'b1;
        #1 chk("rlock_ring_first", 32'({r_local_rdy, r_ring_rdy}), 32'b01);
        step();
        retire();
        chk("rlock_out_ring", 32'({r_out.valid, r_out.data}), 32'h1_00C0);
        step();
        chk("rlock_local_head", 32'({r_out.valid, r_out.data}), 32'h1_00D0);
        in_local = mk(16'h00D1, 1'b1, 1'b1);
        step();
        in_local.valid = 1'b0;
        chk("rlock_local_tail", 32'({r_out.valid, r_out.data}), 32'h1_00D1);

        // Fixed priority: ring starves local, ext served last.
        rst = 1'b0;
        mode = 1;
        in_ring = '0;
        in_local = '0;
        in_ext = '0;
        step();
        step();
        rst = 1'b1;
        in_ring  = mk(16'h00E0, 1'b1, 1'b1);
        in_local = mk(16'h00F0, 1'b1, 1'b1);
        in_ext   = mk(16'h00F8, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1 chk("fp_ring_only", 32'({f_ext_rdy, f_local_rdy, f_ring_rdy}), 32'b001);
            step();
            chk("fp_ring_out", 32'({f_out.valid, f_out.data}), 32'({1'b1, 16'h00E0 + 16'(k)}));
            in_ring.data = in_ring.data + 16'd1;
        end
        in_ring.valid = 1'b0;
        #1 chk("fp_local", 32'({f_ext_rdy, f_local_rdy, f_ring_rdy}), 32'b010);
        step();
        in_local.valid = 1'b0;
        chk("fp_local_out", 32'({f_out.valid, f_out.data}), 32'h1_00F0);
        #1 chk("fp_ext", 32'({f_ext_rdy, f_local_rdy, f_ring_rdy}), 32'b100);
        step();
        in_ext.valid = 1'b0;
        chk("fp_ext_out", 32'({f_out.valid, f_out.data}), 32'h1_00F8);

        run_random(0, 3000);
        run_random(1, 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
